trigger_in: RTL
===============

TRIGGER_IN -- requirements
Module: trigger_in

Interface
REQ-001 Parameter SYNC_WORD, 4'hC: idle/alignment word the upstream serializer sends MSB first; its four rotations are distinct.
REQ-002 Parameter LOCK_CNT, 4: consecutive frame-aligned SYNC_WORD matches required to declare lock (range 2..15).
REQ-003 clk40  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 trig_in  input  1  serial trigger bit stream, MSB of each 4-bit word first, one bit per clk40.
REQ-006 realign  input  1  level; forces loss of lock and a fresh alignment search.
REQ-007 dataout  output  4  last deserialized word, MSB = first bit received.
REQ-008 data_valid  output  1  one-cycle pulse per frame while locked and word != SYNC_WORD.
REQ-009 is_idle  output  1  one-cycle pulse per frame while locked and word == SYNC_WORD.
REQ-010 locked  output  1  high in LOCKED state.
REQ-011 word_cnt  output  16  count of data_valid pulses since lock; saturates at 16'hFFFF.

Function
REQ-012 Shift register sr[3:0] SHALL update every cycle: sr <= {sr[2:0], trig_in}.
REQ-013 FSM states: SEARCH, CHECK, LOCKED; reset state SEARCH.
REQ-014 SEARCH: each cycle the next value of sr is compared with SYNC_WORD; on match: phase counter <= 0, match count <= 1, go CHECK.
REQ-015 Phase counter is 2-bit, increments every cycle outside SEARCH, wraps 3->0; frame boundary = counter wrapping to 0, i.e. 4 cycles after the previous boundary.
REQ-016 CHECK: at each boundary, match -> increment match count and go LOCKED when count reaches LOCK_CNT; mismatch -> SEARCH and resume bitwise search the next cycle.
REQ-017 LOCKED: at each boundary, dataout <= new word; assert is_idle or data_valid (mutually exclusive) the following cycle; dataout held between boundaries.
REQ-018 Latency: dataout/data_valid SHALL be valid exactly 1 cycle after the cycle that samples a word's 4th bit.
REQ-019 LOCKED is left only via realign or reset; there is no automatic loss-of-lock.
REQ-020 realign high in any state: next cycle state = SEARCH, locked/data_valid/is_idle = 0, match count = 0; dataout and word_cnt hold. realign overrides a simultaneous match or boundary.
REQ-021 word_cnt SHALL clear on entry to LOCKED, increment with each data_valid, and not wrap.
REQ-022 A word equal to SYNC_WORD in LOCKED SHALL not count and SHALL not pulse data_valid.

Reset
REQ-023 rst_n low at a clock edge: state SEARCH, sr = 0, phase = 0, match count = 0, dataout = 0, data_valid = 0, is_idle = 0, locked = 0, word_cnt = 0.
REQ-024 Reset mid-frame or mid-lock SHALL discard partial words; the first cycle after rst_n rises performs a SEARCH compare.

Structure
REQ-025 Shared package trigger_pkg holds SYNC_WORD default, LOCK_CNT default, the frame width (4) and the FSM state enum typedef; the upstream serializer uses the same frame width and sync constants.
REQ-026 Single flat module; no sub-module.

Verification
REQ-027 Reset, then stream 4'hC repeated at bit offset 2 -> locked rises on the 4th matched boundary (≈14-16 cycles after first full word), is_idle pulses every 4 cycles thereafter, data_valid stays 0.
REQ-028 Locked, send 4'h5, 4'h9, 4'hC, 4'h3 -> dataout 5, 9, C, 3 at 4-cycle spacing, data_valid 1,1,0,1, is_idle 0,0,1,0, word_cnt = 3.
REQ-029 Three good sync words, then 4'h7 at the boundary in CHECK -> return to SEARCH, locked never asserted; subsequent 4 sync words lock.
REQ-030 Locked, assert realign for 1 cycle coincident with a boundary -> no data_valid/is_idle pulse, locked = 0 next cycle, relock after 4 more sync words with word_cnt = 0.
REQ-031 Force word_cnt to 16'hFFFE, send 3 data words -> word_cnt 16'hFFFF and holds.
REQ-032 rst_n low for 1 cycle mid-data-word while locked -> all outputs 0 next cycle; relock from fresh sync stream.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared constants and FSM state type for the serial trigger link.
// The upstream serializer uses the same frame width and sync constants.
package trigger_pkg;

    localparam int unsigned FRAME_W = 4;
    localparam logic [FRAME_W-1:0] SYNC_WORD_DEF = 4'hC;
    localparam int unsigned LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/trigger_in.sv
// Serial trigger deserializer: finds frame alignment on SYNC_WORD,
// locks after LOCK_CNT aligned matches, then emits one word per frame.
module trigger_in
    import trigger_pkg::*;
#(
    parameter logic [FRAME_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic                clk40,
    input  logic                rst_n,
    input  logic                trig_in,
    input  logic                realign,
    output logic [FRAME_W-1:0]  dataout,
    output logic                data_valid,
    output logic                is_idle,
    output logic                locked,
    output logic [15:0]         word_cnt
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

    state_t              state;
    logic [FRAME_W-1:0]  sr;
    logic [FRAME_W-1:0]  sr_nxt;
    logic [1:0]          phase;
    logic [3:0]          mcnt;
    logic                sync_hit;
    logic                boundary;

    // Compare against the word as it will stand after this edge.
    assign sr_nxt   = {sr[FRAME_W-2:0], trig_in};
    assign sync_hit = (sr_nxt == SYNC_WORD);
    assign boundary = (state != SEARCH) && (phase == 2'd3);

    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            state      <= SEARCH;
            sr         <= '0;
            phase      <= '0;
            mcnt       <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            is_idle    <= 1'b0;
            locked     <= 1'b0;
            word_cnt   <= '0;
        end else begin
            sr         <= sr_nxt;
            data_valid <= 1'b0;
            is_idle    <= 1'b0;
            if (state != SEARCH) begin
                phase <= phase + 2'd1;
            end
            if (realign) begin
                state  <= SEARCH;
                locked <= 1'b0;
                mcnt   <= '0;
                phase  <= '0;
            end else begin
                unique case (state)
                    SEARCH: begin
                        if (sync_hit) begin
                            phase <= '0;
                            mcnt  <= 4'd1;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (boundary) begin
                            if (!sync_hit) begin
                                state <= SEARCH;
                                mcnt  <= '0;
                            end else if (mcnt == LOCK_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                mcnt     <= mcnt + 4'd1;
                                word_cnt <= '0;
                            end else begin
                                mcnt <= mcnt + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
                            dataout <= sr_nxt;
                            if (sync_hit) begin
                                is_idle <= 1'b1;
                            end else begin
                                data_valid <= 1'b1;
                                if (word_cnt != 16'hFFFF) begin
                                    word_cnt <= word_cnt + 16'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        mcnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
